// File: rtl/addseq_pkg.sv
// rtl/addseq_pkg.sv - shared types and width helper for the add/subtract sequencer
//
// addseq_state_e : sequencer FSM states (IDLE / RUN / DONE)
// cnt_w(n)       : bits needed to index n items, never less than 1
package addseq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } addseq_state_e;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/AddCfast.sv
// rtl/AddCfast.sv - shared limb adder with selectable implementation
//
// Ports: a, b (width) operands; ci carry-in; s (width) sum; co carry-out.
// speed = 0 selects a ripple chain, any other value the native adder.
module AddCfast #(
  parameter int width = 8,
  parameter int speed = 0
) (
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  input  logic             ci,
  output logic [width-1:0] s,
  output logic             co
);

  generate
    if (speed == 0) begin : g_ripple
      logic w_c;
      always_comb begin
        w_c = ci;
        s   = '0;
        for (int i = 0; i < width; i++) begin
          s[i] = a[i] ^ b[i] ^ w_c;
          w_c  = (a[i] & b[i]) | (w_c & (a[i] ^ b[i]));
        end
        co = w_c;
      end
    end else begin : g_fast
      assign {co, s} = {1'b0, a} + {1'b0, b} + {{width{1'b0}}, ci};
    end
  endgenerate

endmodule

// File: rtl/addseq_rr_arb.sv
// rtl/addseq_rr_arb.sv - round-robin arbiter holding the priority pointer
//
// Ports: clk_i, rst_ni (async active-low); valid_i (NREQ) requests;
// adv_i moves the pointer past the current winner; grant_o one-hot winner;
// idx_o winner index; any_o some request is valid.
module addseq_rr_arb
  import addseq_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = cnt_w(NREQ)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [NREQ-1:0] valid_i,
  input  logic            adv_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IDW-1:0]  idx_o,
  output logic            any_o
);

  logic [IDW-1:0] r_ptr;
  int             w_j;

  // Scan from the pointer upward, wrapping; the first valid index wins.
  always_comb begin
    any_o = 1'b0;
    idx_o = '0;
    w_j   = 0;
    for (int i = 0; i < NREQ; i++) begin
      w_j = int'(r_ptr) + i;
      if (w_j >= NREQ) w_j = w_j - NREQ;
      for (int k = 0; k < NREQ; k++) begin
        if (!any_o && (k == w_j) && valid_i[k]) begin
          any_o = 1'b1;
          idx_o = IDW'(k);
        end
      end
    end
  end

  always_comb begin
    grant_o = '0;
    for (int i = 0; i < NREQ; i++) begin
      grant_o[i] = any_o && (idx_o == IDW'(i));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ptr <= '0;
    end else if (adv_i) begin
      r_ptr <= (idx_o == IDW'(NREQ - 1)) ? '0 : idx_o + 1'b1;
    end
  end

endmodule

// File: rtl/addseq_ctrl.sv
// rtl/addseq_ctrl.sv - multi-precision add/subtract sequencer over one shared limb adder
//
// Ports: clk_i, rst_ni (async active-low); req_valid_i/req_ready_o per-requester
// handshake; req_a_i/req_b_i operands (slice r per requester); req_ci_i carry-in;
// req_sub_i subtract select; rsp_valid_i/rsp_ready_i response handshake;
// rsp_id_o granted requester; rsp_sum_o sum; rsp_co_o final carry-out.
// Macro ADDSEQ_SUB_EN enables subtraction (B inverted, limb-0 carry forced to 1).
module addseq_ctrl
  import addseq_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int LIMBS = 4,
  parameter  int NREQ  = 2,
  parameter  int SPEED = 0,
  localparam int IDW   = cnt_w(NREQ)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [NREQ-1:0]             req_valid_i,
  output logic [NREQ-1:0]             req_ready_o,
  input  logic [NREQ*LIMBS*WIDTH-1:0] req_a_i,
  input  logic [NREQ*LIMBS*WIDTH-1:0] req_b_i,
  input  logic [NREQ-1:0]             req_ci_i,
  input  logic [NREQ-1:0]             req_sub_i,
  output logic                        rsp_valid_o,
  input  logic                        rsp_ready_i,
  output logic [IDW-1:0]              rsp_id_o,
  output logic [LIMBS*WIDTH-1:0]      rsp_sum_o,
  output logic                        rsp_co_o
);

  localparam int DW = LIMBS * WIDTH;
  localparam int LW = cnt_w(LIMBS);

  addseq_state_e    r_state, w_state_nxt;
  logic [NREQ-1:0]  w_grant;
  logic [IDW-1:0]   w_gidx;
  logic             w_any, w_acc, w_last;
  logic [DW-1:0]    r_a, r_b, r_sum;
  logic             r_ci, r_carry;
  logic [IDW-1:0]   r_id;
  logic [LW-1:0]    r_limb;
  logic [WIDTH-1:0] w_a_limb, w_b_raw, w_b_limb, w_s;
  logic             w_ci, w_co;

  addseq_rr_arb #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .valid_i (req_valid_i),
    .adv_i   (w_acc),
    .grant_o (w_grant),
    .idx_o   (w_gidx),
    .any_o   (w_any)
  );

  // Gated by rst_ni so ready drops immediately when reset asserts.
  assign req_ready_o = (rst_ni && r_state == ST_IDLE) ? w_grant : '0;
  assign w_acc       = (r_state == ST_IDLE) && w_any;
  assign w_last      = (r_limb == LW'(LIMBS - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_acc)       w_state_nxt = ST_RUN;
      ST_RUN:  if (w_last)      w_state_nxt = ST_DONE;
      ST_DONE: if (rsp_ready_i) w_state_nxt = ST_IDLE;
      default:                  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_a_limb = '0;
    w_b_raw  = '0;
    for (int l = 0; l < LIMBS; l++) begin
      if (r_limb == LW'(l)) begin
        w_a_limb = r_a[l*WIDTH +: WIDTH];
        w_b_raw  = r_b[l*WIDTH +: WIDTH];
      end
    end
  end

`ifdef ADDSEQ_SUB_EN
  logic r_sub;
  assign w_b_limb = r_sub ? ~w_b_raw : w_b_raw;
`else
  logic w_unused_sub;
  assign w_b_limb     = w_b_raw;
  assign w_unused_sub = ^req_sub_i;
`endif

  // Limb 0 takes the captured carry-in; later limbs chain the stored carry.
  assign w_ci = (r_limb == '0) ? r_ci : r_carry;

  AddCfast #(.width(WIDTH), .speed(SPEED)) u_add (
    .a  (w_a_limb),
    .b  (w_b_limb),
    .ci (w_ci),
    .s  (w_s),
    .co (w_co)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_a     <= '0;
      r_b     <= '0;
      r_ci    <= 1'b0;
      r_id    <= '0;
      r_limb  <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
`ifdef ADDSEQ_SUB_EN
      r_sub   <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_acc) begin
            r_id   <= w_gidx;
            r_limb <= '0;
            for (int r = 0; r < NREQ; r++) begin
              if (w_gidx == IDW'(r)) begin
                r_a <= req_a_i[r*DW +: DW];
                r_b <= req_b_i[r*DW +: DW];
`ifdef ADDSEQ_SUB_EN
                r_sub <= req_sub_i[r];
                r_ci  <= req_sub_i[r] | req_ci_i[r];
`else
                r_ci  <= req_ci_i[r];
`endif
              end
            end
          end
        end
        ST_RUN: begin
          for (int l = 0; l < LIMBS; l++) begin
            if (r_limb == LW'(l)) r_sum[l*WIDTH +: WIDTH] <= w_s;
          end
          r_carry <= w_co;
          if (!w_last) r_limb <= r_limb + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid_o = (r_state == ST_DONE);
  assign rsp_sum_o   = r_sum;
  assign rsp_co_o    = r_carry;
  assign rsp_id_o    = r_id;

endmodule

// File: tb/tb_addseq_ctrl.sv
// tb/tb_addseq_ctrl.sv - scoreboard bench for addseq_ctrl with a behavioural reference model
module tb_addseq_ctrl;

  localparam int WIDTH = 8;
  localparam int LIMBS = 4;
  localparam int NREQ  = 2;
  localparam int SPEED = 0;
  localparam int DW    = LIMBS * WIDTH;
  localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1;
`ifdef ADDSEQ_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst_ni;
  logic [NREQ-1:0]    req_valid, req_ready, req_ci, req_sub;
  logic [NREQ*DW-1:0] req_a, req_b;
  logic               rsp_valid, rsp_ready, rsp_co;
  logic [IDW-1:0]     rsp_id;
  logic [DW-1:0]      rsp_sum;

  always #5 clk = ~clk;

  addseq_ctrl #(.WIDTH(WIDTH), .LIMBS(LIMBS), .NREQ(NREQ), .SPEED(SPEED)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_a_i     (req_a),
    .req_b_i     (req_b),
    .req_ci_i    (req_ci),
    .req_sub_i   (req_sub),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_id_o    (rsp_id),
    .rsp_sum_o   (rsp_sum),
    .rsp_co_o    (rsp_co)
  );

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [DW-1:0]  sum;
    logic           co;
  } exp_t;

  exp_t           exp_q[$];
  int             checks = 0, errors = 0;
  int             cyc = 0, acc_cyc = 0, acc_cnt = 0;
  int             m_ptr = 0, m_win = 0;
  bit             busy = 0, pend_lat = 0, hold = 0, rand_rdy = 0;
  logic [DW-1:0]  h_sum;
  logic           h_co;
  logic [IDW-1:0] h_id;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp_v);
    end
  endtask

  // Reference result: plain wide arithmetic, independent of limb sequencing.
  function automatic exp_t model(input int r, input logic [DW-1:0] a, input logic [DW-1:0] b,
                                 input logic ci, input logic sub);
    exp_t          e;
    logic [DW:0]   full;
    full = {1'b0, a} + {1'b0, b} + {{DW{1'b0}}, ci};
    if (SUB_EN && sub) begin
      full[DW-1:0] = a - b;
      full[DW]     = (a >= b);
    end
    e.id  = IDW'(r);
    e.sum = full[DW-1:0];
    e.co  = full[DW];
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) rsp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor / scoreboard
  initial begin
    int             win;
    bit             was_busy;
    logic [NREQ-1:0] exp_rdy;
    exp_t           e;
    forever begin
      @(negedge clk);
      if (!rst_ni) begin
        exp_q.delete();
        busy = 0; pend_lat = 0; hold = 0; m_ptr = 0;
      end else begin
        was_busy = busy;
        if (hold) begin
          chk("hold_valid", rsp_valid, 1);
          chk("hold_sum", rsp_sum, h_sum);
          chk("hold_co", rsp_co, h_co);
          chk("hold_id", rsp_id, h_id);
        end
        hold = 0;
        if (busy) chk("ready_in_flight", req_ready, 0);
        if (!was_busy) chk("spurious_rsp", rsp_valid, 0);
        if (pend_lat) begin
          if (rsp_valid) begin
            chk("latency", cyc - acc_cyc, LIMBS + 1);
            pend_lat = 0;
          end else if (cyc - acc_cyc > LIMBS + 1) begin
            chk("latency_timeout", rsp_valid, 1);
            pend_lat = 0;
          end
        end
        if (was_busy && rsp_valid) begin
          if (rsp_ready) begin
            if (exp_q.size() == 0) begin
              chk("unexpected_rsp", 1, 0);
            end else begin
              e = exp_q.pop_front();
              chk("rsp_sum", rsp_sum, e.sum);
              chk("rsp_co", rsp_co, e.co);
              chk("rsp_id", rsp_id, e.id);
            end
            busy = 0;
          end else begin
            hold = 1; h_sum = rsp_sum; h_co = rsp_co; h_id = rsp_id;
          end
        end
        if (!was_busy) begin
          win = -1;
          for (int i = 0; i < NREQ; i++) begin
            if (win < 0 && req_valid[(m_ptr + i) % NREQ]) win = (m_ptr + i) % NREQ;
          end
          exp_rdy = '0;
          if (win >= 0) exp_rdy[win] = 1'b1;
          chk("grant", req_ready, exp_rdy);
          if (win >= 0) begin
            exp_q.push_back(model(win, req_a[win*DW +: DW], req_b[win*DW +: DW],
                                  req_ci[win], req_sub[win]));
            busy = 1; pend_lat = 1; acc_cyc = cyc; acc_cnt++;
            m_win = win;
            m_ptr = (win + 1) % NREQ;
          end
        end
      end
    end
  end

  task automatic set_req(input int r, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic ci, input logic sub);
    req_a[r*DW +: DW] = a;
    req_b[r*DW +: DW] = b;
    req_ci[r]         = ci;
    req_sub[r]        = sub;
    req_valid[r]      = 1'b1;
  endtask

  task automatic wait_acc(input int n, input string name);
    int start = acc_cnt;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      #1;
      if (acc_cnt >= start + n) break;
    end
    chk(name, acc_cnt - start, n);
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0 && !busy) break;
    end
    chk(name, exp_q.size(), 0);
  endtask

  function automatic logic [DW-1:0] rnd();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[DW-1:0];
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 1'b0; req_valid = '0; req_ci = '0; req_sub = '0;
    req_a = '0; req_b = '0; rsp_ready = 1'b1;
    #22 rst_ni = 1'b1;
    @(negedge clk); #1;
    chk("rst_valid", rsp_valid, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_sum", rsp_sum, 0);
    chk("rst_co", rsp_co, 0);
    chk("rst_id", rsp_id, 0);

    // carry ripples through every limb
    @(posedge clk); #1;
    set_req(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    wait_acc(1, "acc_allones");
    @(posedge clk); #1; req_valid = '0;
    drain("drain_allones");

    // carry-in crosses limb boundary
    @(posedge clk); #1;
    set_req(1, 32'h0000_00FF, 32'h0, 1'b1, 1'b0);
    wait_acc(1, "acc_cin");
    @(posedge clk); #1; req_valid = '0;
    drain("drain_cin");

    // both requesters held: alternating grants
    @(posedge clk); #1;
    set_req(0, rnd(), rnd(), 1'b0, 1'b0);
    set_req(1, rnd(), rnd(), 1'b1, 1'b0);
    wait_acc(4, "acc_alternate");
    @(posedge clk); #1; req_valid = '0;
    drain("drain_alternate");

    // response back-pressure for 10 cycles
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    set_req(0, rnd(), rnd(), 1'b0, 1'b0);
    set_req(1, rnd(), rnd(), 1'b0, 1'b0);
    wait_acc(1, "acc_stall");
    @(posedge clk); #1; req_valid[m_win] = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); #1;
      if (rsp_valid) break;
    end
    chk("stall_valid", rsp_valid, 1);
    repeat (10) @(negedge clk);
    @(posedge clk); #1; rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk); #1;
    chk("release_idle", |req_ready, 1);
    @(posedge clk); #1; req_valid = '0;
    drain("drain_stall");

    // subtract request (add when subtraction is compiled out)
    @(posedge clk); #1;
    set_req(0, 32'd5, 32'd7, 1'b0, 1'b1);
    wait_acc(1, "acc_sub");
    @(posedge clk); #1; req_valid = '0;
    drain("drain_sub");

    // randomized traffic with random back-pressure
    rand_rdy = 1;
    for (int it = 0; it < 40; it++) begin
      @(posedge clk); #1;
      begin
        int mask = $urandom_range(1, (1 << NREQ) - 1);
        for (int r = 0; r < NREQ; r++) begin
          if (mask[r]) set_req(r, rnd(), rnd(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
      end
      wait_acc(1, "acc_random");
      @(posedge clk); #1; req_valid = '0;
    end
    rand_rdy = 0;
    @(posedge clk); #1; rsp_ready = 1'b1;
    drain("drain_random");

    // reset in the middle of RUN (limb 2)
    @(posedge clk); #1;
    set_req(0, rnd(), rnd(), 1'b1, 1'b0);
    wait_acc(1, "acc_rst");
    @(posedge clk); #1; req_valid = '0;
    @(posedge clk);
    @(posedge clk); #2;
    set_req(1, rnd(), rnd(), 1'b0, 1'b0);
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_valid", rsp_valid, 0);
    chk("mid_rst_ready", req_ready, 0);
    chk("mid_rst_sum", rsp_sum, 0);
    chk("mid_rst_co", rsp_co, 0);
    chk("mid_rst_id", rsp_id, 0);
    @(negedge clk);
    @(posedge clk); #1;
    set_req(0, rnd(), rnd(), 1'b0, 1'b0);
    #3 rst_ni = 1'b1;
    wait_acc(2, "acc_after_rst");
    @(posedge clk); #1; req_valid = '0;
    drain("drain_after_rst");

    repeat (5) @(negedge clk);
    chk("final_queue", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/addseq_ctrl.md
# addseq_ctrl

Multi-precision add/subtract sequencer that shares a single `AddCfast` limb adder among several requesters. Each request carries two `LIMBS*WIDTH`-bit operands. The block arbitrates round-robin, then feeds the operands through the adder one limb per cycle, least-significant limb first, with the carry chained through a register. It returns the full sum and carry-out over a valid/ready response channel. It sits between wide-arithmetic clients and the shared limb adder, which keeps adder area fixed regardless of operand width.

## Interface
- Clocking: one clock; reset is asynchronous and active-low (`clk_i`, `rst_ni`).
- `WIDTH`, default 8: limb width, also the `AddCfast` width.
- `LIMBS`, default 4: limbs per operand, ≥1.
- `NREQ`, default 2: number of requesters, ≥1.
- `SPEED`, default 0: passed to `AddCfast.speed`.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  async active-low reset.
- `req_valid_i`  in  NREQ  per-requester request valid.
- `req_ready_o`  out  NREQ  per-requester accept; at most one bit high.
- `req_a_i`  in  NREQ*LIMBS*WIDTH  operand A; requester r occupies slice r.
- `req_b_i`  in  NREQ*LIMBS*WIDTH  operand B.
- `req_ci_i`  in  NREQ  carry-in.
- `req_sub_i`  in  NREQ  subtract select; ignored unless `ADDSEQ_SUB_EN`.
- `rsp_valid_o`  out  1  result valid.
- `rsp_ready_i`  in  1  result accept.
- `rsp_id_o`  out  max(1,$clog2(NREQ))  index of the granted requester.
- `rsp_sum_o`  out  LIMBS*WIDTH  sum.
- `rsp_co_o`  out  1  carry-out of the most-significant limb.

## Operation
- **FSM states:** IDLE, RUN, DONE.
- **IDLE:**
  - Round-robin arbitration: the lowest index ≥ `ptr` with `req_valid_i` set wins, wrapping to index 0.
  - `req_ready_o[g]` is driven combinationally high for the winner only.
  - On the handshake edge:
    - capture A, B, CI, SUB and the id;
    - set `ptr` ← (g+1) mod NREQ;
    - set `limb` ← 0;
    - move to RUN.
- **RUN:**
  - Adder inputs: A limb[`limb`], B limb[`limb`], and CI = (`limb`==0 ? captured CI : carry register).
  - Each edge: store the S limb into the result register, set the carry register ← CO, and increment `limb`.
  - At `limb`==LIMBS-1 the edge moves to DONE instead of incrementing.
- **DONE:**
  - `rsp_valid_o`=1.
  - `rsp_sum_o`, `rsp_co_o` and `rsp_id_o` are held stable until `rsp_ready_i`=1.
  - The response handshake edge returns the FSM to IDLE.
- `req_ready_o` is all-zero outside IDLE. Requests are never accepted while a transaction is in flight.
- A requester may drop `req_valid_i` before it is granted without side effects.
- Width rule: the sum is modulo 2^(LIMBS*WIDTH); the overflow appears only on `rsp_co_o`.
- **Reset (any time, including mid-RUN or DONE):**
  - State → IDLE, `ptr` → 0, `limb` → 0, carry → 0.
  - All outputs go to 0 asynchronously.
  - The in-flight transaction is discarded and no response is produced.

## Timing
- Accept edge E0 → `rsp_valid_o` high after edge E0+LIMBS. With the defaults, that is 4 edges.
- Minimum transaction spacing is LIMBS+2 cycles: accept, LIMBS RUN edges, DONE handshake, IDLE cycle.
- The `AddCfast` path is combinational within one cycle. Nothing is registered between the operand limb mux and the result/carry registers.
- With `rsp_ready_i` held high, DONE lasts exactly one cycle.

## Configuration
- Macro: `ADDSEQ_SUB_EN`.
- **Defined:** when the captured SUB=1:
  - the B limbs are inverted before the adder;
  - limb-0 carry-in is forced to 1 and `req_ci_i` is ignored;
  - `rsp_co_o`=1 means no borrow (A≥B).
- **Undefined:**
  - `req_sub_i` is unconnected internally and no SUB state is stored;
  - every transaction is an add.
- The port list is identical in both cases.

## Structure
- Shared package `addseq_pkg` holds:
  - `addseq_state_e` (IDLE/RUN/DONE);
  - the limb-counter width localparam helper.
- Sub-modules:
  - `addseq_rr_arb`: round-robin arbiter with the `ptr` register, grant one-hot, and grant index; NREQ-parameterised.
  - `AddCfast` (existing): one instance for the limb datapath.

## Test plan
- WIDTH=8, LIMBS=4, requester 0: A=0xFFFFFFFF, B=0x00000001, CI=0 → `rsp_sum_o`=0x00000000, `rsp_co_o`=1, `rsp_id_o`=0, with `rsp_valid_o` high exactly 4 edges after accept.
- A=0x000000FF, B=0, CI=1 → sum 0x00000100, co 0. This checks carry propagation across the limb boundary.
- Both `req_valid_i` held high from reset with `rsp_ready_i`=1 → grants alternate 0,1,0,1. `req_ready_o` is never high in RUN or DONE.
- `rsp_ready_i` held 0 for 10 cycles in DONE → the response is held bit-stable and `req_ready_o`=0 throughout. Release → IDLE on the next edge.
- With `ADDSEQ_SUB_EN`: A=5, B=7, SUB=1 → sum 0xFFFFFFFE, co 0. Without the macro, the same stimulus gives sum 0x0000000C, co 0.
- `rst_ni` pulsed low during RUN at limb 2 → all outputs 0 immediately and no response. After release, requester 0 has priority and the next transaction's result is correct.
